spi_line_streamer: RTL
======================

Name: spi_line_streamer

Overview:
- Parametrised successor to the single-line VGA SPI ROM reader.
- Fetches a configurable number of bits per line from SPI flash into a ping-pong line buffer, so every VGA line is painted from memory. There is no stored/direct alternation.
- Generates SCLK from a registered clk/2 toggle instead of an inverted clock. Supports READ (03h) and FAST READ (0Bh + dummy byte).
- Sits between vga_sync and the pixel colour logic in the top level.

Parameters:
- BUFFER_DEPTH, 128, data bits fetched per line; size of each of the 2 banks.
- ADDR_LEN, 24, address bits sent after the command.
- FAST_READ, 0, 0 selects CMD 03h with no dummy bits; 1 selects CMD 0Bh followed by 8 dummy bits.
- IDX_W, $clog2(BUFFER_DEPTH), width of the read index.

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  asynchronous reset, active low.
- fetch_start  in  1  one-cycle pulse requesting a fetch into the write bank.
- fetch_addr  in  ADDR_LEN  flash byte address, latched on an accepted fetch_start.
- swap  in  1  one-cycle pulse at line start that exchanges the display and write banks.
- rd_index  in  IDX_W  bit index into the display bank.
- rd_data  out  1  display-bank bit at rd_index (combinational).
- busy  out  1  high while a fetch is in progress.
- fetch_done  out  1  one-cycle pulse when a fetch completes.
- overrun  out  1  sticky flag: a swap arrived while busy.
- spi_cs  out  1  chip select, active HIGH; the parent inverts it.
- spi_sclk  out  1  SPI clock, clk/2, registered.
- spi_mosi  out  1  serial command/address out.
- spi_miso  in  1  serial data in.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: spi_cs=0, spi_sclk=0, spi_mosi=0, busy=0, fetch_done=0, overrun=0.
  - Internal: state=IDLE, disp_bank=0, both banks cleared to 0.
  - Asserting reset mid-fetch aborts immediately: cs drops and no fetch_done is issued.
- Stream length: STREAM_LEN = 8 + ADDR_LEN + 8*FAST_READ + BUFFER_DEPTH bits. Each bit takes 2 clk (phase 0: sclk=0; phase 1: sclk=1).
- FSM:
  - IDLE -> CMD when fetch_start=1. On that edge, latch fetch_addr, clear bit counter and phase; spi_cs=1 from the next cycle.
  - CMD: 8 bits, MSB first.
  - CMD -> ADDR: ADDR_LEN bits, MSB first.
  - ADDR -> DUMMY (FAST_READ=1: 8 bits, mosi=0) or ADDR -> DATA.
  - DATA: BUFFER_DEPTH bits; mosi=0.
  - DATA -> IDLE after the last sample: cs=0 and fetch_done=1 in the same cycle.
- Bit timing:
  - MOSI changes only on the clk edge entering phase 0 (sclk low), so it is stable at the sclk rise.
  - MISO is sampled on the clk edge that ends phase 1 (sclk 1->0).
- Total: spi_cs high for exactly 2*STREAM_LEN cycles; busy == spi_cs.
- spi_sclk idles 0 whenever cs=0 (SPI mode 0).
- Buffer write: the k-th DATA bit received goes to write_bank[k]. Write bank = ~disp_bank. Index 0 = MSB of the first byte.
- rd_data = disp_bank[rd_index], with zero latency.
- swap:
  - When busy=0, flip disp_bank on the next edge.
  - When busy=1, ignore the swap and set overrun=1 (held until reset); the display bank is unchanged.
- fetch_start while busy: ignored; no effect on overrun.
- fetch_start and swap in the same cycle while idle: the swap takes effect first, and the fetch writes into the post-swap write bank.
- fetch_addr is not masked or wrapped; flash-side wrap is the device's concern.
- Counters are sized to hold STREAM_LEN-1 and never wrap mid-fetch.

Decomposition:
- spi_rom_pkg holds:
  - CMD_READ=8'h03, CMD_FAST_READ=8'h0B, DUMMY_BITS=8;
  - FSM state encoding (IDLE, CMD, ADDR, DUMMY, DATA);
  - the STREAM_LEN function.
- One sub-module is natural: line_buffer_2bank.
  - Ports: wr_en, wr_idx, wr_bit, swap_en, rd_idx, rd_bit.
  - Owns disp_bank; the FSM and SPI shifter stay in the top.

Test Plan:
- Default READ, fetch_addr=24'h000120:
  - MOSI shows 0x03 then 0x000120, MSB first.
  - cs high exactly 320 cycles; fetch_done pulses once as cs falls; sclk toggles 160 times.
- FAST_READ=1, fetch_addr=24'h001000:
  - MOSI shows 0x0B, the address, then 8 zero bits.
  - cs high 336 cycles; the first stored bit is the one sampled after the dummy byte.
- Flash model returns 0xA5 repeating:
  - After fetch then swap, rd_index 0..7 reads 1,0,1,0,0,1,0,1.
  - The previous display bank is unchanged until the swap.
- Swap pulsed at cycle 100 of a fetch: overrun=1, disp_bank unchanged, fetch completes normally, overrun stays 1.
- Swap and fetch_start in the same idle cycle: disp_bank flips, and the new data lands in the bank that was displayed before the swap.
- reset_n low at cycle 50 of a fetch: cs/sclk/busy go 0 asynchronously with no fetch_done; a new fetch after release runs a full 320 cycles.

Source files
------------

// File: rtl/spi_line_streamer_pkg.sv
// Shared constants, FSM encoding and stream-length helper for the SPI line streamer.
package spi_rom_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         DUMMY_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } state_t;

  // Total SPI bits per fetch: command byte, address, optional dummy byte, line data.
  function automatic int stream_len(input int buffer_depth, input int addr_len,
                                    input int fast_read);
    return 8 + addr_len + DUMMY_BITS * fast_read + buffer_depth;
  endfunction

endpackage

// File: rtl/spi_line_streamer_if.sv
// SPI flash pins as seen by the line streamer (master) and the flash device (slave).
interface spi_line_streamer_if;

  logic spi_cs;    // active high; the parent inverts it for the flash pin
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sclk, input spi_mosi, output spi_miso);

endinterface

// File: rtl/spi_line_streamer_line_buffer_2bank.sv
// Two-bank line buffer: one bank is displayed while the other is filled by the fetch.
module line_buffer_2bank #(
  parameter int BUFFER_DEPTH = 128,
  parameter int IDX_W        = $clog2(BUFFER_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit,
  input  logic             swap_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_bit,
  output logic             disp_bank
);

  logic [BUFFER_DEPTH-1:0] bank0_q, bank0_d;
  logic [BUFFER_DEPTH-1:0] bank1_q, bank1_d;
  logic                    disp_q, disp_d;

  // Writes always target the bank that is not on screen.
  always_comb begin
    disp_d  = disp_q ^ swap_en;
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    if (wr_en) begin
      if (disp_q) bank0_d[wr_idx] = wr_bit;
      else        bank1_d[wr_idx] = wr_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q <= '0;
      bank1_q <= '0;
      disp_q  <= 1'b0;
    end else begin
      bank0_q <= bank0_d;
      bank1_q <= bank1_d;
      disp_q  <= disp_d;
    end
  end

  assign rd_bit    = disp_q ? bank1_q[rd_idx] : bank0_q[rd_idx];
  assign disp_bank = disp_q;

endmodule

// File: rtl/spi_line_streamer.sv
// Fetches one video line of bits from SPI flash (READ or FAST READ) into a ping-pong buffer.
module spi_line_streamer
  import spi_rom_pkg::*;
#(
  parameter int BUFFER_DEPTH = 128,
  parameter int ADDR_LEN     = 24,
  parameter int FAST_READ    = 0,
  parameter int IDX_W        = $clog2(BUFFER_DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  // fetch_start and swap are single-cycle requests with no ready: they are acted on
  // only while busy is low; fetch_done pulses once when a fetch lands in the buffer.
  input  logic                fetch_start,
  input  logic [ADDR_LEN-1:0] fetch_addr,
  input  logic                swap,
  input  logic [IDX_W-1:0]    rd_index,
  output logic                rd_data,
  output logic                busy,
  output logic                fetch_done,
  output logic                overrun,
  spi_line_streamer_if.master spi,
  output state_t              dbg_state,
  output logic                dbg_disp_bank
);

  localparam int STREAM_LEN = stream_len(BUFFER_DEPTH, ADDR_LEN, FAST_READ);
  localparam int CNT_W      = $clog2(STREAM_LEN);
  localparam int HDR_W      = 8 + ADDR_LEN;
  localparam int DATA_START = HDR_W + DUMMY_BITS * FAST_READ;

  localparam logic [7:0]       CMD_BYTE   = (FAST_READ != 0) ? CMD_FAST_READ : CMD_READ;
  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DATA_START - 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(STREAM_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_BASE  = CNT_W'(DATA_START);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [HDR_W-1:0]   shreg_q, shreg_d;
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               swap_en;

  assign busy    = (state_q != IDLE);
  assign swap_en = swap & ~busy;
  assign wr_idx  = IDX_W'(cnt_q - DATA_BASE);

  // Every bit ends on the edge leaving phase 1: MISO is captured and MOSI shifts then,
  // so MOSI is already settled when SCLK next rises.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = 1'b0;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (swap & busy);
    wr_en     = 1'b0;
    if (state_q == IDLE) begin
      if (fetch_start) begin
        state_d = CMD;
        cnt_d   = '0;
        shreg_d = {CMD_BYTE, fetch_addr};
      end
    end else begin
      phase_d = ~phase_q;
      if (phase_q) begin
        cnt_d   = cnt_q + CNT_W'(1);
        shreg_d = shreg_q << 1;
        case (state_q)
          CMD:   if (cnt_q == LAST_CMD) state_d = ADDR;
          ADDR:  if (cnt_q == LAST_ADDR) state_d = (FAST_READ != 0) ? DUMMY : DATA;
          DUMMY: if (cnt_q == LAST_DUMMY) state_d = DATA;
          DATA: begin
            wr_en = 1'b1;
            if (cnt_q == LAST_BIT) begin
              state_d = IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      shreg_q   <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      shreg_q   <= shreg_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  line_buffer_2bank #(
    .BUFFER_DEPTH (BUFFER_DEPTH),
    .IDX_W        (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_bit    (spi.spi_miso),
    .swap_en   (swap_en),
    .rd_idx    (rd_index),
    .rd_bit    (rd_data),
    .disp_bank (dbg_disp_bank)
  );

  assign spi.spi_cs   = busy;
  assign spi.spi_sclk = phase_q;
  assign spi.spi_mosi = ((state_q == CMD) || (state_q == ADDR)) ? shreg_q[HDR_W-1] : 1'b0;
  assign fetch_done   = done_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule
